// File: rtl/serial_word_tx.sv
// serial_word_tx
//   Parallel-to-serial front end for the serial two's-complement datapath.
//   A WIDTH-bit word is taken over a valid/ready handshake and shifted out
//   one bit per clock, LSB first, with first/last framing strobes. An
//   optional idle gap after each word lets the downstream complementer's
//   registered output drain before the next word starts.
//
// Parameters
//   WIDTH      : bits per word (2..32)
//   GAP_CYCLES : idle cycles after each word's last bit (0..15)
//
// Ports
//   clk       : rising-edge clock
//   reset     : synchronous, active-high reset
//   in_data   : parallel word to serialise
//   in_valid  : in_data is valid
//   in_ready  : block can accept a word this cycle
//   out_bit   : serial data, LSB first
//   out_valid : out_bit carries a word bit this cycle
//   out_first : out_bit is bit 0 of a word
//   out_last  : out_bit is bit WIDTH-1 of a word
//   busy      : block is not idle
module serial_word_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  // Only meaningful when GAP_CYCLES > 0; the GAP state is unreachable otherwise.
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_gcnt;

  logic w_last_bit;
  logic w_ready;
  logic w_xfer;

  assign w_last_bit = (r_state == SHIFT) && (r_cnt == CNT_LAST);

  // With no gap, the last-bit cycle doubles as the accept cycle for the
  // next word so that words stream back to back.
  assign w_ready = !reset &&
                   ((r_state == IDLE) || ((GAP_CYCLES == 0) && w_last_bit));
  assign w_xfer  = in_valid && w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_gcnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_shreg <= in_data;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          // Zero fill drains the register, so out_bit idles at 0.
          r_shreg <= r_shreg >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            if (GAP_CYCLES > 0) begin
              r_state <= GAP;
              r_gcnt  <= '0;
            end else if (w_xfer) begin
              r_shreg <= in_data;
              r_cnt   <= '0;
              r_state <= SHIFT;
            end else begin
              r_state <= IDLE;
            end
          end
        end

        GAP: begin
          r_gcnt <= r_gcnt + 1'b1;
          if (r_gcnt == GAP_LAST) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // All framing outputs decode from flops only; no path from in_data/in_valid.
  assign in_ready  = w_ready;
  assign out_bit   = r_shreg[0];
  assign out_valid = (r_state == SHIFT);
  assign out_first = out_valid && (r_cnt == '0);
  assign out_last  = w_last_bit;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_serial_word_tx.sv
module tb_serial_word_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       vin;
  logic [7:0] din;
  int         sel;

  always #5 clk = ~clk;

  // Instance A: WIDTH=8, GAP=1; B: WIDTH=8, GAP=0; C: WIDTH=2, GAP=15.
  logic va, vb, vc;
  logic rdy_a, bit_a, vld_a, fst_a, lst_a, bsy_a;
  logic rdy_b, bit_b, vld_b, fst_b, lst_b, bsy_b;
  logic rdy_c, bit_c, vld_c, fst_c, lst_c, bsy_c;

  assign va = vin && (sel == 0);
  assign vb = vin && (sel == 1);
  assign vc = vin && (sel == 2);

  serial_word_tx #(.WIDTH(8), .GAP_CYCLES(1)) u_a (
    .clk(clk), .reset(reset), .in_data(din), .in_valid(va), .in_ready(rdy_a),
    .out_bit(bit_a), .out_valid(vld_a), .out_first(fst_a), .out_last(lst_a),
    .busy(bsy_a)
  );

  serial_word_tx #(.WIDTH(8), .GAP_CYCLES(0)) u_b (
    .clk(clk), .reset(reset), .in_data(din), .in_valid(vb), .in_ready(rdy_b),
    .out_bit(bit_b), .out_valid(vld_b), .out_first(fst_b), .out_last(lst_b),
    .busy(bsy_b)
  );

  serial_word_tx #(.WIDTH(2), .GAP_CYCLES(15)) u_c (
    .clk(clk), .reset(reset), .in_data(din[1:0]), .in_valid(vc), .in_ready(rdy_c),
    .out_bit(bit_c), .out_valid(vld_c), .out_first(fst_c), .out_last(lst_c),
    .busy(bsy_c)
  );

  // Observed instance selected by sel.
  logic o_rdy, o_bit, o_vld, o_fst, o_lst, o_bsy;
  always_comb begin
    o_rdy = rdy_a; o_bit = bit_a; o_vld = vld_a;
    o_fst = fst_a; o_lst = lst_a; o_bsy = bsy_a;
    if (sel == 1) begin
      o_rdy = rdy_b; o_bit = bit_b; o_vld = vld_b;
      o_fst = fst_b; o_lst = lst_b; o_bsy = bsy_b;
    end else if (sel == 2) begin
      o_rdy = rdy_c; o_bit = bit_c; o_vld = vld_c;
      o_fst = fst_c; o_lst = lst_c; o_bsy = bsy_c;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stimulus schedule: index c is the value present at rising edge c
  // (driven during cycle c). Samples: index c is cycle c, which follows edge c-1.
  logic       v_s [0:39];
  logic [7:0] d_s [0:39];
  logic       r_s [0:39];
  logic       s_bit [0:39];
  logic       s_vld [0:39];
  logic       s_fst [0:39];
  logic       s_lst [0:39];
  logic       s_bsy [0:39];
  logic       s_rdy [0:39];

  task automatic clr_sched();
    for (int i = 0; i < 40; i++) begin
      v_s[i] = 1'b0; d_s[i] = 8'h00; r_s[i] = 1'b0;
    end
  endtask

  task automatic run(input int n);
    vin = v_s[0]; din = d_s[0]; reset = r_s[0];
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      s_bit[c] = o_bit; s_vld[c] = o_vld; s_fst[c] = o_fst;
      s_lst[c] = o_lst; s_bsy[c] = o_bsy; s_rdy[c] = o_rdy;
      vin = v_s[c]; din = d_s[c]; reset = r_s[c];
    end
  endtask

  function automatic logic [7:0] word_at(input int start);
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[i] = s_bit[start + i];
    return w;
  endfunction

  // Downstream serial two's complementer: pass bits up to and including
  // the first 1, invert everything after it.
  function automatic logic [7:0] comp_at(input int start);
    logic [7:0] w;
    logic       seen;
    logic       b;
    w = '0; seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b    = s_bit[start + i];
      w[i] = seen ? ~b : b;
      seen = seen | b;
    end
    return w;
  endfunction

  initial begin
    int first_rdy;
    int nlast;

    sel = 0; vin = 1'b0; din = 8'h00; reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bit",   o_bit, 0);
    chk("rst_valid", o_vld, 0);
    chk("rst_first", o_fst, 0);
    chk("rst_last",  o_lst, 0);
    chk("rst_busy",  o_bsy, 0);
    chk("rst_ready", o_rdy, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", o_rdy, 1);

    // Word 0x06 on W=8, GAP=1
    sel = 0;
    clr_sched(); v_s[0] = 1'b1; d_s[0] = 8'h06;
    run(10);
    chk("t1_word", word_at(1), 8'h06);
    chk("t1_comp", comp_at(1), 8'hFA);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("t1_valid_c%0d", c), s_vld[c], (c <= 8));
      chk($sformatf("t1_first_c%0d", c), s_fst[c], (c == 1));
      chk($sformatf("t1_last_c%0d",  c), s_lst[c], (c == 8));
      chk($sformatf("t1_busy_c%0d",  c), s_bsy[c], (c <= 9));
      chk($sformatf("t1_ready_c%0d", c), s_rdy[c], (c == 10));
    end

    // Word 0x80 through the complementer stays 0x80
    clr_sched(); v_s[0] = 1'b1; d_s[0] = 8'h80;
    run(10);
    chk("t2_word", word_at(1), 8'h80);
    chk("t2_comp", comp_at(1), 8'h80);
    chk("t2_last_c8", s_lst[8], 1);

    // GAP=0 back-to-back: 0xA5 then 0x3C with in_valid held high
    sel = 1;
    clr_sched();
    v_s[0] = 1'b1; d_s[0] = 8'hA5;
    for (int i = 1; i <= 8; i++) begin v_s[i] = 1'b1; d_s[i] = 8'h3C; end
    run(18);
    chk("b2b_word0", word_at(1), 8'hA5);
    chk("b2b_word1", word_at(9), 8'h3C);
    for (int c = 1; c <= 17; c++) begin
      chk($sformatf("b2b_valid_c%0d", c), s_vld[c], (c <= 16));
      chk($sformatf("b2b_first_c%0d", c), s_fst[c], (c == 1 || c == 9));
      chk($sformatf("b2b_last_c%0d",  c), s_lst[c], (c == 8 || c == 16));
    end

    // in_valid pulse with 0xFF during cycles 3-5 of word 0x01 is ignored
    sel = 0;
    clr_sched();
    v_s[0] = 1'b1; d_s[0] = 8'h01;
    for (int i = 3; i <= 5; i++) begin v_s[i] = 1'b1; d_s[i] = 8'hFF; end
    run(10);
    for (int c = 1; c <= 8; c++)
      chk($sformatf("pulse_bit_c%0d", c), s_bit[c], (c == 1));
    chk("pulse_valid_c9", s_vld[9], 0);
    chk("pulse_busy_c9",  s_bsy[9], 1);
    chk("pulse_ready_c10", s_rdy[10], 1);

    // Reset in cycle 4 of word 0xFF, then word 0x81
    clr_sched();
    v_s[0] = 1'b1; d_s[0] = 8'hFF;
    r_s[4] = 1'b1;
    v_s[5] = 1'b1; d_s[5] = 8'h81;
    run(16);
    for (int c = 1; c <= 4; c++)
      chk($sformatf("abort_bit_c%0d", c), s_bit[c], 1);
    chk("abort_bit_c5",   s_bit[5], 0);
    chk("abort_valid_c5", s_vld[5], 0);
    chk("abort_first_c5", s_fst[5], 0);
    chk("abort_last_c5",  s_lst[5], 0);
    chk("abort_busy_c5",  s_bsy[5], 0);
    chk("abort_ready_c5", s_rdy[5], 0);
    nlast = 0;
    for (int c = 1; c <= 5; c++) nlast += s_lst[c];
    chk("abort_no_last", nlast, 0);
    chk("after_word",   word_at(6), 8'h81);
    chk("after_first6", s_fst[6], 1);
    chk("after_first7", s_fst[7], 0);
    chk("after_last13", s_lst[13], 1);
    chk("after_valid14", s_vld[14], 0);

    // WIDTH=2, GAP=15, word 0x2
    sel = 2;
    clr_sched(); v_s[0] = 1'b1; d_s[0] = 8'h02;
    run(20);
    chk("w2_bit_c1",   s_bit[1], 0);
    chk("w2_bit_c2",   s_bit[2], 1);
    chk("w2_first_c1", s_fst[1], 1);
    chk("w2_last_c2",  s_lst[2], 1);
    chk("w2_valid_c3", s_vld[3], 0);
    chk("w2_busy_c17", s_bsy[17], 1);
    chk("w2_busy_c18", s_bsy[18], 0);
    first_rdy = 0;
    for (int c = 1; c <= 20; c++)
      if (first_rdy == 0 && s_rdy[c]) first_rdy = c;
    chk("w2_first_ready_cycle", first_rdy, 18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
